// File: rtl/rpn_pkg.sv
// Shared types for the RPN calculator controller: FSM state codes (as shown on out_Status)
// and error codes (as shown on err_code).
package rpn_pkg;

    localparam int DEF_OPW = 3;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PUSH      = 3'd1,
        EXEC      = 3'd2,
        WAIT_ALU  = 3'd3,
        WRITE_RES = 3'd4,
        ERROR     = 3'd7
    } state_t;

    typedef enum logic [2:0] {
        ERR_NONE = 3'd0,
        ERR_OVF  = 3'd1,
        ERR_UNF  = 3'd2,
        ERR_ALU  = 3'd3,
        ERR_TMO  = 3'd4
    } err_t;

endpackage

// File: rtl/rpn_stack_ctrl_if.sv
// Bundles the user-entry, ALU handshake and display/status signals of rpn_stack_ctrl.
// slave = the controller; master = the environment around it (front end, ALU, display).
interface rpn_stack_ctrl_if #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4,
    parameter int OPW   = rpn_pkg::DEF_OPW
);
    localparam int CW = $clog2(DEPTH + 1);

    logic             enter_pulse;
    logic             enter_is_op;
    logic [WIDTH-1:0] data_in;
    logic [OPW-1:0]   opcode_in;
    logic             clear_pulse;
    logic             alu_done;
    logic             alu_error;
    logic [WIDTH-1:0] alu_result;
    logic             alu_start;
    logic [WIDTH-1:0] alu_op_a;
    logic [WIDTH-1:0] alu_op_b;
    logic [OPW-1:0]   alu_opcode;
    logic [WIDTH-1:0] display_val;
    logic [CW-1:0]    stack_count;
    logic [2:0]       out_Status;
    logic [2:0]       err_code;

    modport slave (
        input  enter_pulse, enter_is_op, data_in, opcode_in, clear_pulse,
               alu_done, alu_error, alu_result,
        output alu_start, alu_op_a, alu_op_b, alu_opcode,
               display_val, stack_count, out_Status, err_code
    );

    modport master (
        output enter_pulse, enter_is_op, data_in, opcode_in, clear_pulse,
               alu_done, alu_error, alu_result,
        input  alu_start, alu_op_a, alu_op_b, alu_opcode,
               display_val, stack_count, out_Status, err_code
    );
endinterface

// File: rtl/rpn_operand_stack.sv
// Operand stack of DEPTH x WIDTH registers; push or replace2 (pop two, push one) take one cycle.
// top/next are read combinationally from the registers; no backpressure, the caller checks count.
module rpn_operand_stack #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic                         replace2,
    input  logic                         clear,
    input  logic [WIDTH-1:0]             push_dat,
    input  logic [WIDTH-1:0]             res_dat,
    output logic [WIDTH-1:0]             top,
    output logic [WIDTH-1:0]             next,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [CW-1:0]    sp;
    logic [AW-1:0]    wr_idx;
    logic [AW-1:0]    top_idx;
    logic [AW-1:0]    next_idx;

    assign wr_idx   = AW'(sp);
    assign top_idx  = AW'(sp - CW'(1));
    assign next_idx = AW'(sp - CW'(2));

    // Empty slots read as zero so the display shows 0 after a clear without wiping entries.
    assign top   = (sp == '0)      ? '0 : mem[top_idx];
    assign next  = (sp < CW'(2))   ? '0 : mem[next_idx];
    assign count = sp;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sp <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (clear) begin
            sp <= '0;
        end else if (push) begin
            mem[wr_idx] <= push_dat;
            sp          <= sp + CW'(1);
        end else if (replace2) begin
            mem[next_idx] <= res_dat;
            sp            <= sp - CW'(1);
        end
    end
endmodule

// File: rtl/rpn_stack_ctrl.sv
// RPN controller: operand push visible on display 2 cycles after entry; operator runs the ALU via start/done.
// Entries arriving outside IDLE are dropped (no queuing); clear_pulse overrides everything.
module rpn_stack_ctrl #(
    parameter int WIDTH       = 16,
    parameter int DEPTH       = 4,
    parameter int OPW         = rpn_pkg::DEF_OPW,
    parameter int ALU_TIMEOUT = 64
) (
    input  logic           clk,
    input  logic           reset,
    rpn_stack_ctrl_if.slave bus
);
    import rpn_pkg::*;

    localparam int CW = $clog2(DEPTH + 1);
    localparam int TW = $clog2(ALU_TIMEOUT);

    state_t           state;
    err_t             err;
    logic [OPW-1:0]   opcode_q;
    logic             alu_start_q;
    logic [TW-1:0]    cnt;
    logic [WIDTH-1:0] din_q;
    logic [WIDTH-1:0] res_q;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] top;
    logic [WIDTH-1:0] next;
    logic             push;
    logic             replace2;

    assign push     = (state == PUSH);
    assign replace2 = (state == WRITE_RES);

    rpn_operand_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_stack (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .replace2 (replace2),
        .clear    (bus.clear_pulse),
        .push_dat (din_q),
        .res_dat  (res_q),
        .top      (top),
        .next     (next),
        .count    (count)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            err         <= ERR_NONE;
            opcode_q    <= '0;
            alu_start_q <= 1'b0;
            cnt         <= '0;
            din_q       <= '0;
            res_q       <= '0;
        end else if (bus.clear_pulse) begin
            state       <= IDLE;
            err         <= ERR_NONE;
            alu_start_q <= 1'b0;
            cnt         <= '0;
        end else begin
            alu_start_q <= 1'b0;
            case (state)
                IDLE: if (bus.enter_pulse) begin
                    if (!bus.enter_is_op) begin
                        if (count < CW'(DEPTH)) begin
                            din_q <= bus.data_in;
                            state <= PUSH;
                        end else begin
                            err   <= ERR_OVF;
                            state <= ERROR;
                        end
                    end else if (count >= CW'(2)) begin
                        opcode_q    <= bus.opcode_in;
                        alu_start_q <= 1'b1;
                        state       <= EXEC;
                    end else begin
                        err   <= ERR_UNF;
                        state <= ERROR;
                    end
                end
                PUSH:  state <= IDLE;
                EXEC: begin
                    cnt   <= '0;
                    state <= WAIT_ALU;
                end
                // A done arriving in the final counted cycle still wins over the timeout.
                WAIT_ALU: begin
                    if (bus.alu_done) begin
                        if (bus.alu_error) begin
                            err   <= ERR_ALU;
                            state <= ERROR;
                        end else begin
                            res_q <= bus.alu_result;
                            state <= WRITE_RES;
                        end
                    end else if (cnt == TW'(ALU_TIMEOUT - 1)) begin
                        err   <= ERR_TMO;
                        state <= ERROR;
                    end else begin
                        cnt <= cnt + TW'(1);
                    end
                end
                WRITE_RES: state <= IDLE;
                ERROR:     state <= ERROR;
                default:   state <= IDLE;
            endcase
        end
    end

    assign bus.alu_start   = alu_start_q;
    assign bus.alu_op_a    = next;
    assign bus.alu_op_b    = top;
    assign bus.alu_opcode  = opcode_q;
    assign bus.display_val = top;
    assign bus.stack_count = count;
    assign bus.out_Status  = state;
    assign bus.err_code    = err;
endmodule

// File: tb/tb_rpn_stack_ctrl.sv
// Directed bench for rpn_stack_ctrl with hand-computed expectations per scenario.
module tb_rpn_stack_ctrl;
    localparam int W = 16;
    localparam int D = 4;
    localparam int O = 3;
    localparam int T = 10;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   start_cnt = 0;

    rpn_stack_ctrl_if #(.WIDTH(W), .DEPTH(D), .OPW(O)) bus ();

    rpn_stack_ctrl #(.WIDTH(W), .DEPTH(D), .OPW(O), .ALU_TIMEOUT(T)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (bus.alu_start === 1'b1) start_cnt++;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic enter(input logic is_op, input logic [W-1:0] val, input logic [O-1:0] opc);
        bus.enter_pulse = 1'b1;
        bus.enter_is_op = is_op;
        bus.data_in     = val;
        bus.opcode_in   = opc;
        step();
        bus.enter_pulse = 1'b0;
    endtask

    task automatic push_val(input logic [W-1:0] val);
        enter(1'b0, val, '0);
        step();
    endtask

    task automatic do_clear();
        bus.clear_pulse = 1'b1;
        step();
        bus.clear_pulse = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if (bus.out_Status !== 3'd0) begin errors++; $display("FAIL reset_status got %0d exp 0", bus.out_Status); end
        checks++; if (bus.stack_count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", bus.stack_count); end
        checks++; if (bus.display_val !== 16'd0) begin errors++; $display("FAIL reset_display got %0h exp 0", bus.display_val); end
        checks++; if (bus.err_code !== 3'd0) begin errors++; $display("FAIL reset_err got %0d exp 0", bus.err_code); end
        checks++; if (bus.alu_start !== 1'b0) begin errors++; $display("FAIL reset_start got %0b exp 0", bus.alu_start); end
        checks++; if (bus.alu_opcode !== 3'd0) begin errors++; $display("FAIL reset_opcode got %0d exp 0", bus.alu_opcode); end
    endtask

    task automatic test_basic();
        int s0;
        enter(1'b0, 16'd5, '0);
        checks++; if (bus.out_Status !== 3'd1) begin errors++; $display("FAIL push_state got %0d exp 1", bus.out_Status); end
        checks++; if (bus.display_val !== 16'd0) begin errors++; $display("FAIL push_early got %0d exp 0", bus.display_val); end
        step();
        checks++; if (bus.display_val !== 16'd5) begin errors++; $display("FAIL push_latency got %0d exp 5", bus.display_val); end
        push_val(16'd3);
        s0 = start_cnt;
        enter(1'b1, '0, 3'd0);
        checks++; if (bus.out_Status !== 3'd2) begin errors++; $display("FAIL exec_state got %0d exp 2", bus.out_Status); end
        checks++; if (bus.alu_start !== 1'b1) begin errors++; $display("FAIL exec_start got %0b exp 1", bus.alu_start); end
        checks++; if (bus.alu_op_a !== 16'd5 || bus.alu_op_b !== 16'd3) begin errors++; $display("FAIL exec_ops got %0d,%0d exp 5,3", bus.alu_op_a, bus.alu_op_b); end
        step();
        checks++; if (bus.out_Status !== 3'd3 || bus.alu_start !== 1'b0) begin errors++; $display("FAIL wait_state got %0d/%0b exp 3/0", bus.out_Status, bus.alu_start); end
        step();
        step();
        bus.alu_done = 1'b1; bus.alu_result = 16'd8;
        step();
        bus.alu_done = 1'b0;
        checks++; if (bus.out_Status !== 3'd4) begin errors++; $display("FAIL write_state got %0d exp 4", bus.out_Status); end
        step();
        checks++; if (bus.display_val !== 16'd8) begin errors++; $display("FAIL basic_display got %0d exp 8", bus.display_val); end
        checks++; if (bus.stack_count !== 3'd1) begin errors++; $display("FAIL basic_count got %0d exp 1", bus.stack_count); end
        checks++; if (bus.err_code !== 3'd0) begin errors++; $display("FAIL basic_err got %0d exp 0", bus.err_code); end
        checks++; if (start_cnt - s0 !== 1) begin errors++; $display("FAIL basic_starts got %0d exp 1", start_cnt - s0); end
        push_val(16'd2);
        enter(1'b1, '0, 3'd6);
        checks++; if (bus.alu_opcode !== 3'd6) begin errors++; $display("FAIL op2_opcode got %0d exp 6", bus.alu_opcode); end
        checks++; if (bus.alu_op_a !== 16'd8 || bus.alu_op_b !== 16'd2) begin errors++; $display("FAIL op2_ops got %0d,%0d exp 8,2", bus.alu_op_a, bus.alu_op_b); end
        step();
        bus.alu_done = 1'b1; bus.alu_result = 16'hFFFF;
        step();
        bus.alu_done = 1'b0;
        step();
        checks++; if (bus.display_val !== 16'hFFFF || bus.stack_count !== 3'd1) begin errors++; $display("FAIL op2_result got %0h/%0d exp ffff/1", bus.display_val, bus.stack_count); end
        do_clear();
    endtask

    task automatic test_overflow();
        for (int i = 1; i <= 4; i++) push_val(W'(i));
        enter(1'b0, 16'd5, '0);
        checks++; if (bus.out_Status !== 3'd7 || bus.err_code !== 3'd1) begin errors++; $display("FAIL ovf_state got %0d/%0d exp 7/1", bus.out_Status, bus.err_code); end
        checks++; if (bus.stack_count !== 3'd4 || bus.display_val !== 16'd4) begin errors++; $display("FAIL ovf_stack got %0d/%0d exp 4/4", bus.stack_count, bus.display_val); end
        step();
        checks++; if (bus.out_Status !== 3'd7) begin errors++; $display("FAIL ovf_hold got %0d exp 7", bus.out_Status); end
        do_clear();
        checks++; if (bus.stack_count !== 3'd0 || bus.display_val !== 16'd0) begin errors++; $display("FAIL clear_stack got %0d/%0d exp 0/0", bus.stack_count, bus.display_val); end
        checks++; if (bus.out_Status !== 3'd0 || bus.err_code !== 3'd0) begin errors++; $display("FAIL clear_state got %0d/%0d exp 0/0", bus.out_Status, bus.err_code); end
    endtask

    task automatic test_underflow();
        int s0;
        push_val(16'd7);
        s0 = start_cnt;
        enter(1'b1, '0, 3'd1);
        checks++; if (bus.out_Status !== 3'd7 || bus.err_code !== 3'd2) begin errors++; $display("FAIL unf_state got %0d/%0d exp 7/2", bus.out_Status, bus.err_code); end
        step();
        checks++; if (start_cnt !== s0) begin errors++; $display("FAIL unf_start got %0d exp %0d", start_cnt, s0); end
        checks++; if (bus.stack_count !== 3'd1 || bus.display_val !== 16'd7) begin errors++; $display("FAIL unf_stack got %0d/%0d exp 1/7", bus.stack_count, bus.display_val); end
        do_clear();
    endtask

    task automatic test_timeout();
        int n;
        n = 0;
        push_val(16'd1);
        push_val(16'd2);
        enter(1'b1, '0, 3'd2);
        step();
        for (int i = 0; i < 4 * T; i++) begin
            step();
            n++;
            if (bus.out_Status === 3'd7) break;
        end
        checks++; if (n !== T) begin errors++; $display("FAIL tmo_cycles got %0d exp %0d", n, T); end
        checks++; if (bus.err_code !== 3'd4) begin errors++; $display("FAIL tmo_err got %0d exp 4", bus.err_code); end
        bus.alu_done = 1'b1; bus.alu_result = 16'd99;
        step();
        bus.alu_done = 1'b0;
        step();
        checks++; if (bus.out_Status !== 3'd7 || bus.stack_count !== 3'd2 || bus.display_val !== 16'd2) begin errors++; $display("FAIL tmo_late_done got %0d/%0d/%0d exp 7/2/2", bus.out_Status, bus.stack_count, bus.display_val); end
        do_clear();
    endtask

    task automatic test_alu_error();
        push_val(16'd9);
        push_val(16'd0);
        enter(1'b1, '0, 3'd3);
        step();
        bus.alu_done = 1'b1; bus.alu_error = 1'b1;
        step();
        bus.alu_done = 1'b0; bus.alu_error = 1'b0;
        checks++; if (bus.out_Status !== 3'd7 || bus.err_code !== 3'd3) begin errors++; $display("FAIL aluerr_state got %0d/%0d exp 7/3", bus.out_Status, bus.err_code); end
        checks++; if (bus.stack_count !== 3'd2 || bus.alu_op_a !== 16'd9 || bus.alu_op_b !== 16'd0) begin errors++; $display("FAIL aluerr_stack got %0d/%0d/%0d exp 2/9/0", bus.stack_count, bus.alu_op_a, bus.alu_op_b); end
        enter(1'b0, 16'd6, '0);
        step();
        checks++; if (bus.out_Status !== 3'd7 || bus.stack_count !== 3'd2 || bus.display_val !== 16'd0) begin errors++; $display("FAIL err_ignore got %0d/%0d/%0d exp 7/2/0", bus.out_Status, bus.stack_count, bus.display_val); end
        do_clear();
    endtask

    task automatic test_back_to_back();
        enter(1'b0, 16'd10, '0);
        enter(1'b0, 16'd20, '0);
        step();
        checks++; if (bus.stack_count !== 3'd1 || bus.display_val !== 16'd10) begin errors++; $display("FAIL b2b_drop got %0d/%0d exp 1/10", bus.stack_count, bus.display_val); end
        do_clear();
    endtask

    task automatic test_reset_wait();
        push_val(16'd2);
        push_val(16'd4);
        enter(1'b1, '0, 3'd4);
        step();
        checks++; if (bus.out_Status !== 3'd3 || bus.alu_op_a !== 16'd2 || bus.alu_op_b !== 16'd4) begin errors++; $display("FAIL rw_wait got %0d/%0d/%0d exp 3/2/4", bus.out_Status, bus.alu_op_a, bus.alu_op_b); end
        #2 reset = 1'b0;
        #1;
        checks++; if (bus.out_Status !== 3'd0 || bus.alu_start !== 1'b0 || bus.alu_opcode !== 3'd0) begin errors++; $display("FAIL rw_async got %0d/%0b/%0d exp 0/0/0", bus.out_Status, bus.alu_start, bus.alu_opcode); end
        checks++; if (bus.stack_count !== 3'd0 || bus.display_val !== 16'd0 || bus.err_code !== 3'd0) begin errors++; $display("FAIL rw_async_stack got %0d/%0d/%0d exp 0/0/0", bus.stack_count, bus.display_val, bus.err_code); end
        step();
        reset = 1'b1;
        bus.alu_done = 1'b1; bus.alu_result = 16'd77;
        step();
        bus.alu_done = 1'b0;
        step();
        checks++; if (bus.out_Status !== 3'd0 || bus.stack_count !== 3'd0) begin errors++; $display("FAIL rw_late_done got %0d/%0d exp 0/0", bus.out_Status, bus.stack_count); end
    endtask

    task automatic test_clear_enter();
        push_val(16'd11);
        bus.clear_pulse = 1'b1;
        enter(1'b0, 16'd22, '0);
        bus.clear_pulse = 1'b0;
        checks++; if (bus.out_Status !== 3'd0 || bus.stack_count !== 3'd0) begin errors++; $display("FAIL ce_state got %0d/%0d exp 0/0", bus.out_Status, bus.stack_count); end
        step();
        checks++; if (bus.stack_count !== 3'd0 || bus.display_val !== 16'd0) begin errors++; $display("FAIL ce_nopush got %0d/%0d exp 0/0", bus.stack_count, bus.display_val); end
    endtask

    initial begin
        bus.enter_pulse = 1'b0;
        bus.enter_is_op = 1'b0;
        bus.data_in     = '0;
        bus.opcode_in   = '0;
        bus.clear_pulse = 1'b0;
        bus.alu_done    = 1'b0;
        bus.alu_error   = 1'b0;
        bus.alu_result  = '0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        reset = 1'b1;
        step();
        test_basic();
        test_overflow();
        test_underflow();
        test_timeout();
        test_alu_error();
        test_back_to_back();
        test_reset_wait();
        test_clear_enter();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
